kernel_feed_ctrl: RTL and testbench

Row-sequencing controller that feeds the 3-row kernel cell of the systolic array. It accepts a raster-order pixel stream with a val/rdy handshake and buffers the two previous image rows internally. Each cycle it presents a vertically aligned pixel triple (x1 = row r-2, x2 = row r-1, x3 = row r) with per-row valids and a `new_row` marker. It also tracks frame position and signals frame completion once the downstream kernel pipeline has drained.

---
 rtl/kernel_feed_pkg.sv | 19 +
 rtl/kernel_feed_ctrl_if.sv | 31 +++
 rtl/kernel_line_buffer.sv | 32 +++
 rtl/kernel_feed_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_kernel_feed_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kernel_feed_pkg.sv
// Shared types and default geometry for the kernel feed controller.
// COL_W/ROW_W describe the default 640x480 geometry; modules with other
// geometries derive their own widths from their parameters.
package kernel_feed_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StStream,
        StDrain,
        StDone
    } feed_state_t;

    localparam int unsigned DEF_IMG_W = 640;
    localparam int unsigned DEF_IMG_H = 480;
    localparam int unsigned COL_W     = $clog2(DEF_IMG_W);
    localparam int unsigned ROW_W     = $clog2(DEF_IMG_H);

endpackage

// File: rtl/kernel_feed_ctrl_if.sv
// Pixel stream in, aligned kernel triple out, plus frame control/status.
// master: the side driving pixels and start; slave: the feed controller.
interface kernel_feed_ctrl_if #(
    parameter int unsigned PIX_W = 8
) ();

    logic             start;
    logic             in_val;
    logic             in_rdy;
    logic [PIX_W-1:0] in_msg;
    logic [PIX_W-1:0] x1;
    logic [PIX_W-1:0] x2;
    logic [PIX_W-1:0] x3;
    logic             x1_val;
    logic             x2_val;
    logic             x3_val;
    logic             new_row;
    logic             busy;
    logic             done;

    modport master (
        output start, in_val, in_msg,
        input  in_rdy, x1, x2, x3, x1_val, x2_val, x3_val, new_row, busy, done
    );

    modport slave (
        input  start, in_val, in_msg,
        output in_rdy, x1, x2, x3, x1_val, x2_val, x3_val, new_row, busy, done
    );

endinterface

// File: rtl/kernel_line_buffer.sv
// One image row of storage: synchronous write, combinational read at the
// same address, so a read-then-write in one cycle returns the old value.
// Contents are intentionally not reset.
module kernel_line_buffer
    import kernel_feed_pkg::*;
#(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned DEPTH = DEF_IMG_W,
    parameter int unsigned AW    = COL_W
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [PIX_W-1:0] wdata_i,
    output logic [PIX_W-1:0] rdata_o
);

    logic [PIX_W-1:0] mem_q [DEPTH];

    // Row storage write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read port sees the pre-write contents.
    always_comb begin
        rdata_o = mem_q[addr_i];
    end

endmodule

// File: rtl/kernel_feed_ctrl.sv
// kernel_feed_ctrl: buffers the two previous rows of a raster pixel stream and
// presents vertically aligned triples (r-2, r-1, r) to the 3-row kernel cell.
// Tracks frame position and pulses done once the downstream pipe has drained.
// Build macro KERNEL_FEED_ZERO_PAD_EN: rows 0 and 1 emit full triples with
// the missing rows forced to zero.
module kernel_feed_ctrl
    import kernel_feed_pkg::*;
#(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned IMG_W = DEF_IMG_W,
    parameter int unsigned IMG_H = DEF_IMG_H,
    parameter int unsigned DRAIN = 5
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    kernel_feed_ctrl_if.slave feed_io
);

    localparam int unsigned     ColW      = $clog2(IMG_W);
    localparam int unsigned     RowW      = $clog2(IMG_H);
    localparam logic [ColW-1:0] ColLast   = ColW'(IMG_W - 1);
    localparam logic [RowW-1:0] RowLast   = RowW'(IMG_H - 1);
    localparam logic [2:0]      DrainLast = 3'(DRAIN - 1);

    feed_state_t      state_q;
    logic [ColW-1:0]  col_q;
    logic [RowW-1:0]  row_q;
    logic [2:0]       drain_cnt_q;
    logic             in_rdy_q;
    logic             busy_q;
    logic             done_q;

    logic [PIX_W-1:0] x1_q;
    logic [PIX_W-1:0] x2_q;
    logic [PIX_W-1:0] x3_q;
    logic             x1_val_q;
    logic             x2_val_q;
    logic             x3_val_q;
    logic             new_row_q;

    logic             fire;
    logic             last_col;
    logic             row_end;
    logic [PIX_W-1:0] lb1_rdata;
    logic [PIX_W-1:0] lb2_rdata;

    // Handshake and row-boundary decode.
    always_comb begin
        fire     = feed_io.in_val && in_rdy_q;
        last_col = (col_q == ColLast);
        row_end  = fire && last_col;
    end

    // LB1 holds row r-1; it is written with the incoming pixel.
    kernel_line_buffer #(
        .PIX_W (PIX_W),
        .DEPTH (IMG_W),
        .AW    (ColW)
    ) u_lb1 (
        .clk_i   (clk_i),
        .we_i    (fire),
        .addr_i  (col_q),
        .wdata_i (feed_io.in_msg),
        .rdata_o (lb1_rdata)
    );

    // LB2 holds row r-2; it takes over the pixel LB1 is about to overwrite.
    kernel_line_buffer #(
        .PIX_W (PIX_W),
        .DEPTH (IMG_W),
        .AW    (ColW)
    ) u_lb2 (
        .clk_i   (clk_i),
        .we_i    (fire),
        .addr_i  (col_q),
        .wdata_i (lb1_rdata),
        .rdata_o (lb2_rdata)
    );

    // Frame FSM with position counters, drain counter and registered status.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            col_q       <= '0;
            row_q       <= '0;
            drain_cnt_q <= '0;
            in_rdy_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (fire) begin
                if (last_col) begin
                    col_q <= '0;
                    row_q <= (row_q == RowLast) ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (feed_io.start) begin
                        state_q  <= StFill;
                        col_q    <= '0;
                        row_q    <= '0;
                        in_rdy_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                StFill: begin
                    // Once row 1 is in, both line buffers hold real data.
                    if (row_end && (row_q == RowW'(1))) begin
                        state_q <= StStream;
                    end
                end
                StStream: begin
                    if (row_end && (row_q == RowLast)) begin
                        state_q     <= StDrain;
                        in_rdy_q    <= 1'b0;
                        drain_cnt_q <= '0;
                    end
                end
                StDrain: begin
                    if (drain_cnt_q == DrainLast) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 3'd1;
                    end
                end
                StDone: begin
                    // start here is dropped: a new frame must begin from idle.
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= StIdle;
                    in_rdy_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    // Output triple: valids pulse for one cycle per fire, data holds otherwise.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            x1_q      <= '0;
            x2_q      <= '0;
            x3_q      <= '0;
            x1_val_q  <= 1'b0;
            x2_val_q  <= 1'b0;
            x3_val_q  <= 1'b0;
            new_row_q <= 1'b0;
        end else begin
            x3_val_q  <= fire;
            new_row_q <= fire && (col_q == '0);
`ifdef KERNEL_FEED_ZERO_PAD_EN
            x2_val_q  <= fire;
            x1_val_q  <= fire;
`else
            x2_val_q  <= fire && (row_q >= RowW'(1));
            x1_val_q  <= fire && (row_q >= RowW'(2));
`endif
            if (fire) begin
                x3_q <= feed_io.in_msg;
`ifdef KERNEL_FEED_ZERO_PAD_EN
                // Rows above the frame top read as zero, not stale buffer data.
                x2_q <= (row_q < RowW'(1)) ? '0 : lb1_rdata;
                x1_q <= (row_q < RowW'(2)) ? '0 : lb2_rdata;
`else
                x2_q <= lb1_rdata;
                x1_q <= lb2_rdata;
`endif
            end
        end
    end

    // Drive the interface from the registered state.
    always_comb begin
        feed_io.in_rdy  = in_rdy_q;
        feed_io.busy    = busy_q;
        feed_io.done    = done_q;
        feed_io.x1      = x1_q;
        feed_io.x2      = x2_q;
        feed_io.x3      = x3_q;
        feed_io.x1_val  = x1_val_q;
        feed_io.x2_val  = x2_val_q;
        feed_io.x3_val  = x3_val_q;
        feed_io.new_row = new_row_q;
    end

endmodule

// File: tb/tb_kernel_feed_ctrl.sv
// Bench for kernel_feed_ctrl: 4x3 frames, pixel = row*16 + col. A frame-level
// model (pixel index, image array, drain countdown) predicts every output each
// cycle; literal checks pin key triples, new_row placement and done timing.
module tb_kernel_feed_ctrl;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned IMG_W = 4;
    localparam int unsigned IMG_H = 3;
    localparam int unsigned DRAIN = 5;
    localparam int          NPIX  = IMG_W * IMG_H;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    kernel_feed_ctrl_if #(.PIX_W(PIX_W)) feed_if ();

    kernel_feed_ctrl #(
        .PIX_W (PIX_W),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .DRAIN (DRAIN)
    ) dut (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .feed_io  (feed_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int idx);
        pix = 8'(((idx / IMG_W) * 16) + (idx % IMG_W));
    endfunction

    // ---------------- frame-level reference model ----------------
    bit         m_busy = 0;
    bit         m_rdy  = 0;
    int         m_cnt  = 0;
    int         m_left = 0;
    bit         m_fire;
    bit         m_was_busy;
    int         m_r;
    int         m_c;
    bit         e_done = 0;
    bit         e_x1v  = 0;
    bit         e_x2v  = 0;
    bit         e_x3v  = 0;
    bit         e_nr   = 0;
    logic [7:0] e_x1   = '0;
    logic [7:0] e_x2   = '0;
    logic [7:0] e_x3   = '0;
    bit         k1     = 1;
    bit         k2     = 1;
    logic [7:0] img [IMG_H][IMG_W];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_rdy = 0; m_cnt = 0; m_left = 0; e_done = 0;
            e_x1v = 0; e_x2v = 0; e_x3v = 0; e_nr = 0;
            e_x1 = '0; e_x2 = '0; e_x3 = '0; k1 = 1; k2 = 1;
        end else begin
            m_was_busy = m_busy;
            m_fire     = feed_if.in_val && m_rdy;
            if (e_done) begin
                e_done = 0;
                m_busy = 0;
            end
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) e_done = 1;
            end
            e_x3v = m_fire; e_nr = 0; e_x2v = 0; e_x1v = 0;
            if (m_fire) begin
                m_r = m_cnt / IMG_W;
                m_c = m_cnt % IMG_W;
                img[m_r][m_c] = feed_if.in_msg;
                e_x3 = feed_if.in_msg;
                e_nr = (m_c == 0);
`ifdef KERNEL_FEED_ZERO_PAD_EN
                e_x2v = 1; e_x1v = 1; k2 = 1; k1 = 1;
                e_x2 = (m_r >= 1) ? img[m_r-1][m_c] : 8'h00;
                e_x1 = (m_r >= 2) ? img[m_r-2][m_c] : 8'h00;
`else
                e_x2v = (m_r >= 1); k2 = (m_r >= 1);
                e_x1v = (m_r >= 2); k1 = (m_r >= 2);
                if (m_r >= 1) e_x2 = img[m_r-1][m_c];
                if (m_r >= 2) e_x1 = img[m_r-2][m_c];
`endif
                m_cnt++;
                if (m_cnt == NPIX) begin
                    m_rdy  = 0;
                    m_left = DRAIN;
                end
            end
            if (feed_if.start && !m_was_busy) begin
                m_busy = 1; m_rdy = 1; m_cnt = 0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("in_rdy",  32'(feed_if.in_rdy),  32'(m_rdy));
        chk("busy",    32'(feed_if.busy),    32'(m_busy));
        chk("done",    32'(feed_if.done),    32'(e_done));
        chk("x3_val",  32'(feed_if.x3_val),  32'(e_x3v));
        chk("x2_val",  32'(feed_if.x2_val),  32'(e_x2v));
        chk("x1_val",  32'(feed_if.x1_val),  32'(e_x1v));
        chk("new_row", 32'(feed_if.new_row), 32'(e_nr));
        chk("x3",      32'(feed_if.x3),      32'(e_x3));
        if (k2) chk("x2", 32'(feed_if.x2), 32'(e_x2));
        if (k1) chk("x1", 32'(feed_if.x1), 32'(e_x1));
    end

    // Observation log of every emitted triple, for the literal checks.
    logic [7:0] obs_x1 [128];
    logic [7:0] obs_x2 [128];
    logic [7:0] obs_x3 [128];
    logic [2:0] obs_fl [128];
    logic       obs_nr [128];
    int         obs_total    = 0;
    int         last_out_cyc = -1;
    int         done_cyc     = -1;

    always @(negedge clk) begin
        if (feed_if.done === 1'b1) done_cyc = cyc;
        if (feed_if.x3_val === 1'b1) begin
            if (obs_total < 128) begin
                obs_x1[obs_total] = feed_if.x1;
                obs_x2[obs_total] = feed_if.x2;
                obs_x3[obs_total] = feed_if.x3;
                obs_fl[obs_total] = {feed_if.x1_val, feed_if.x2_val, feed_if.x3_val};
                obs_nr[obs_total] = feed_if.new_row;
            end
            obs_total++;
            last_out_cyc = cyc;
        end
    end

    // ---------------- stimulus ----------------
    int fbase;
    int fstart_cyc;

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic run_frame(input bit bubbles, input int mid_start_at, input int abort_at,
                             output bit aborted);
        int budget;
        bit val_t;
        bit pulsed;
        aborted    = 0;
        pulsed     = 0;
        val_t      = 1;
        fbase      = obs_total;
        fstart_cyc = cyc;
        feed_if.start = 1'b1;
        step();
        feed_if.start = 1'b0;
        budget = 0;
        while (m_rdy && budget < 200) begin
            if (abort_at >= 0 && m_cnt == abort_at) begin
                feed_if.in_val = 1'b0;
                reset_n = 1'b0;
                step();
                step();
                reset_n = 1'b1;
                aborted = 1;
                break;
            end
            feed_if.in_val = bubbles ? val_t : 1'b1;
            val_t = ~val_t;
            feed_if.in_msg = pix(m_cnt);
            if (m_cnt == mid_start_at && !pulsed) begin
                feed_if.start = 1'b1;
                pulsed = 1;
            end else begin
                feed_if.start = 1'b0;
            end
            step();
            budget++;
        end
        feed_if.in_val = 1'b0;
        feed_if.start  = 1'b0;
        chk("frame_feed_bound", 32'(budget >= 200), 32'd0);
        if (!aborted) begin
            budget = 0;
            while (done_cyc <= fstart_cyc && budget < 40) begin
                step();
                budget++;
            end
            chk("done_wait_bound", 32'(budget >= 40), 32'd0);
            step();
        end
    endtask

    task automatic check_frame_literals();
        logic [11:0] nr_mask;
        nr_mask = '0;
        chk("frame_pixel_count", 32'(obs_total - fbase), 32'd12);
        chk("r2c1_x1", 32'(obs_x1[fbase+9]), 32'h01);
        chk("r2c1_x2", 32'(obs_x2[fbase+9]), 32'h11);
        chk("r2c1_x3", 32'(obs_x3[fbase+9]), 32'h21);
        chk("r2c1_valids", 32'(obs_fl[fbase+9]), 32'b111);
        chk("r0c3_x3", 32'(obs_x3[fbase+3]), 32'h03);
`ifdef KERNEL_FEED_ZERO_PAD_EN
        chk("r0c3_x1", 32'(obs_x1[fbase+3]), 32'h00);
        chk("r0c3_x2", 32'(obs_x2[fbase+3]), 32'h00);
        chk("r0c3_valids", 32'(obs_fl[fbase+3]), 32'b111);
`else
        chk("r0c3_valids", 32'(obs_fl[fbase+3]), 32'b001);
        chk("r1c0_valids", 32'(obs_fl[fbase+4]), 32'b011);
`endif
        for (int i = 0; i < 12; i++) nr_mask[i] = obs_nr[fbase+i];
        chk("new_row_positions", 32'(nr_mask), 32'h111);
        chk("done_after_last_fire", 32'(done_cyc - (last_out_cyc - 1)), 32'd6);
    endtask

    initial begin
        bit ab;
        int n0;
        feed_if.start  = 1'b0;
        feed_if.in_val = 1'b0;
        feed_if.in_msg = '0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        step(); step(); step();

        // Reset state, and in_rdy stays low without start.
        chk("rst_in_rdy", 32'(feed_if.in_rdy), 32'd0);
        chk("rst_busy",   32'(feed_if.busy),   32'd0);
        chk("rst_done",   32'(feed_if.done),   32'd0);
        chk("rst_x3",     32'(feed_if.x3),     32'd0);
        chk("rst_x3_val", 32'(feed_if.x3_val), 32'd0);

        // in_val while idle must not fire.
        n0 = obs_total;
        feed_if.in_val = 1'b1;
        feed_if.in_msg = 8'hAA;
        repeat (4) step();
        feed_if.in_val = 1'b0;
        chk("idle_no_outputs", 32'(obs_total - n0), 32'd0);
        step();

        run_frame(1'b0, -1, -1, ab);
        check_frame_literals();

        run_frame(1'b1, -1, -1, ab);
        check_frame_literals();

        run_frame(1'b0, 5, -1, ab);
        check_frame_literals();

        run_frame(1'b0, -1, 6, ab);
        step();
        chk("after_abort_busy", 32'(feed_if.busy), 32'd0);
        run_frame(1'b0, -1, -1, ab);
        check_frame_literals();

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
